// File: rtl/config_pkg.sv
// Derived core configuration consumed by the data-cache flush walker.
package config_pkg;

   typedef struct packed {
      int unsigned DCACHE_INDEX_WIDTH;
      int unsigned DCACHE_OFFSET_WIDTH;
      int unsigned DCACHE_SET_ASSOC;
      int unsigned DCACHE_SET_ASSOC_WIDTH;
      logic        DcacheFlushOnFence;
      logic        DcacheInvalidateOnFlush;
   } cva6_cfg_t;

   // Baseline geometry: 256 sets of 16-byte lines, 8 ways, flush on fence.
   localparam cva6_cfg_t cva6_cfg_empty = '{
      DCACHE_INDEX_WIDTH:      12,
      DCACHE_OFFSET_WIDTH:     4,
      DCACHE_SET_ASSOC:        8,
      DCACHE_SET_ASSOC_WIDTH:  3,
      DcacheFlushOnFence:      1'b1,
      DcacheInvalidateOnFlush: 1'b0
   };

endpackage

// File: rtl/dcache_flush_walker.sv
// Walks every set/way of the write-back D-cache on fence or flush, reading
// tag status per set and issuing writeback and/or invalidate line operations.
module dcache_flush_walker #(
   parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
   localparam int unsigned SetW = CVA6Cfg.DCACHE_INDEX_WIDTH - CVA6Cfg.DCACHE_OFFSET_WIDTH,
   localparam int unsigned Ways = CVA6Cfg.DCACHE_SET_ASSOC,
   localparam int unsigned WayW = CVA6Cfg.DCACHE_SET_ASSOC_WIDTH
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            fence_i,
   input  logic            flush_i,
   output logic            busy_o,
   output logic            done_o,
   output logic            tag_req_o,
   input  logic            tag_gnt_i,
   output logic [SetW-1:0] tag_set_o,
   input  logic [Ways-1:0] valid_i,
   input  logic [Ways-1:0] dirty_i,
   output logic            line_req_o,
   input  logic            line_gnt_i,
   output logic [SetW-1:0] line_set_o,
   output logic [WayW-1:0] line_way_o,
   output logic            line_wb_o,
   output logic            line_inv_o
);

   typedef enum logic [2:0] {IDLE, READ, WAIT, SCAN, DONE} state_e;

   state_e            state_q, nxt_state;
   logic [SetW-1:0]   set_q, nxt_set;
   logic [Ways-1:0]   mask_q, nxt_mask;
   logic [Ways-1:0]   dirty_q, nxt_dirty;
   logic              inv_q, nxt_inv;
   logic [WayW-1:0]   cur_way, nxt_way;
   logic              nxt_line_req;

   // Lowest-numbered set bit of a way mask (0 when empty).
   function automatic logic [WayW-1:0] lowest_way(input logic [Ways-1:0] m);
      logic [WayW-1:0] r;
      r = '0;
      for (int unsigned i = Ways; i > 0; i--) begin
         if (m[i-1]) r = WayW'(i - 1);
      end
      return r;
   endfunction

   // Next-state, next-set and mask bookkeeping for the walk.
   always_comb begin
      nxt_state = state_q;
      nxt_set   = set_q;
      nxt_mask  = mask_q;
      nxt_dirty = dirty_q;
      nxt_inv   = inv_q;
      cur_way   = lowest_way(mask_q);
      case (state_q)
         IDLE: begin
            if (flush_i || (fence_i && CVA6Cfg.DcacheFlushOnFence)) begin
               nxt_state = READ;
               nxt_set   = '0;
               nxt_inv   = flush_i | CVA6Cfg.DcacheInvalidateOnFlush;
            end else if (fence_i) begin
               nxt_state = DONE;
            end
         end
         READ: begin
            if (tag_gnt_i) nxt_state = WAIT;
         end
         WAIT: begin
            nxt_mask  = inv_q ? valid_i : (valid_i & dirty_i);
            nxt_dirty = dirty_i;
            nxt_state = SCAN;
         end
         SCAN: begin
            if (mask_q != '0) begin
               if (line_gnt_i) nxt_mask[cur_way] = 1'b0;
            end else if (set_q == '1) begin
               nxt_state = DONE;
            end else begin
               nxt_set   = set_q + 1'b1;
               nxt_state = READ;
            end
         end
         DONE: nxt_state = IDLE;
         default: nxt_state = IDLE;
      endcase
      nxt_way      = lowest_way(nxt_mask);
      nxt_line_req = (nxt_state == SCAN) && (nxt_mask != '0);
   end

   // State registers; outputs are registered from the next-state values so
   // each one reflects the state it is asserted in.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         set_q      <= '0;
         mask_q     <= '0;
         dirty_q    <= '0;
         inv_q      <= 1'b0;
         busy_o     <= 1'b0;
         done_o     <= 1'b0;
         tag_req_o  <= 1'b0;
         tag_set_o  <= '0;
         line_req_o <= 1'b0;
         line_set_o <= '0;
         line_way_o <= '0;
         line_wb_o  <= 1'b0;
         line_inv_o <= 1'b0;
      end else begin
         state_q    <= nxt_state;
         set_q      <= nxt_set;
         mask_q     <= nxt_mask;
         dirty_q    <= nxt_dirty;
         inv_q      <= nxt_inv;
         busy_o     <= (nxt_state != IDLE);
         done_o     <= (nxt_state == DONE);
         tag_req_o  <= (nxt_state == READ);
         tag_set_o  <= (nxt_state == READ) ? nxt_set : '0;
         line_req_o <= nxt_line_req;
         line_set_o <= nxt_line_req ? nxt_set : '0;
         line_way_o <= nxt_line_req ? nxt_way : '0;
         line_wb_o  <= nxt_line_req ? nxt_dirty[nxt_way] : 1'b0;
         line_inv_o <= nxt_line_req ? nxt_inv : 1'b0;
      end
   end

endmodule

// File: tb/tb_dcache_flush_walker.sv
// Directed bench for dcache_flush_walker: tag-array responder, line-op
// recorder and hand-computed walk latencies.
module tb_dcache_flush_walker;

   localparam config_pkg::cva6_cfg_t CFG_A = '{
      DCACHE_INDEX_WIDTH: 12, DCACHE_OFFSET_WIDTH: 4, DCACHE_SET_ASSOC: 8,
      DCACHE_SET_ASSOC_WIDTH: 3, DcacheFlushOnFence: 1'b1, DcacheInvalidateOnFlush: 1'b0};
   localparam config_pkg::cva6_cfg_t CFG_B = '{
      DCACHE_INDEX_WIDTH: 12, DCACHE_OFFSET_WIDTH: 4, DCACHE_SET_ASSOC: 8,
      DCACHE_SET_ASSOC_WIDTH: 3, DcacheFlushOnFence: 1'b0, DcacheInvalidateOnFlush: 1'b0};

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       fence = 1'b0, flush = 1'b0;
   logic       busy, done, tag_req, line_req, line_wb, line_inv;
   logic       tag_gnt = 1'b1, line_gnt = 1'b1;
   logic [7:0] tag_set, line_set, valid = '0, dirty = '0;
   logic [2:0] line_way;

   logic       b_fence = 1'b0;
   logic       b_busy, b_done, b_tag_req, b_line_req, b_line_wb, b_line_inv;
   logic [7:0] b_tag_set, b_line_set;
   logic [2:0] b_line_way;

   always #5 clk = ~clk;

   dcache_flush_walker #(.CVA6Cfg(CFG_A)) dut_a (
      .clk_i(clk), .rst_i(rst), .fence_i(fence), .flush_i(flush),
      .busy_o(busy), .done_o(done), .tag_req_o(tag_req), .tag_gnt_i(tag_gnt),
      .tag_set_o(tag_set), .valid_i(valid), .dirty_i(dirty),
      .line_req_o(line_req), .line_gnt_i(line_gnt), .line_set_o(line_set),
      .line_way_o(line_way), .line_wb_o(line_wb), .line_inv_o(line_inv));

   dcache_flush_walker #(.CVA6Cfg(CFG_B)) dut_b (
      .clk_i(clk), .rst_i(rst), .fence_i(b_fence), .flush_i(1'b0),
      .busy_o(b_busy), .done_o(b_done), .tag_req_o(b_tag_req), .tag_gnt_i(1'b1),
      .tag_set_o(b_tag_set), .valid_i(8'h00), .dirty_i(8'h00),
      .line_req_o(b_line_req), .line_gnt_i(1'b1), .line_set_o(b_line_set),
      .line_way_o(b_line_way), .line_wb_o(b_line_wb), .line_inv_o(b_line_inv));

   int n_checks = 0, n_fail = 0;

   task automatic check(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Tag-array contents, per set.
   logic [7:0] tv [256];
   logic [7:0] td [256];

   // Monitor state.
   int   n_reads, n_ops, exp_set, seq_err, overlap, stable_err, stall_left, b_tag_cnt;
   logic stalling;
   logic [12:0] snap, cur;
   int   op_set [16], op_way [16], op_wb [16], op_inv [16];

   // Tag responder, line-grant driver and traffic recorder.
   always @(negedge clk) begin
      if (tag_req && line_req) overlap++;
      if (b_tag_req || b_line_req) b_tag_cnt++;
      if (tag_req && tag_gnt) begin
         if (int'(tag_set) != exp_set) seq_err++;
         exp_set++;
         n_reads++;
         valid = tv[tag_set];
         dirty = td[tag_set];
      end
      if (line_req) begin
         cur = {line_set, line_way, line_wb, line_inv};
         if (stalling && cur != snap) stable_err++;
         if (stall_left > 0) begin
            if (!stalling) snap = cur;
            stalling = 1'b1;
            stall_left--;
            line_gnt = 1'b0;
         end else begin
            line_gnt = 1'b1;
            stalling = 1'b0;
            if (n_ops < 16) begin
               op_set[n_ops] = int'(line_set);
               op_way[n_ops] = int'(line_way);
               op_wb[n_ops]  = int'(line_wb);
               op_inv[n_ops] = int'(line_inv);
            end
            n_ops++;
         end
      end
   end

   task automatic clear_mon();
      n_reads = 0; n_ops = 0; exp_set = 0; seq_err = 0; overlap = 0;
      stable_err = 0; stalling = 1'b0;
   endtask

   // Returns the cycle (counted from the start edge) in which done is seen.
   task automatic run_walk(input logic fe, input logic fl, output int lat);
      @(negedge clk);
      clear_mon();
      fence = fe;
      flush = fl;
      @(posedge clk);
      lat = -1;
      for (int c = 1; c <= 3000; c++) begin
         @(negedge clk);
         if (done) begin
            lat = c;
            break;
         end
      end
      fence = 1'b0;
      flush = 1'b0;
   endtask

   int lat;
   int found;

   initial begin
      foreach (tv[i]) begin tv[i] = '0; td[i] = '0; end
      stall_left = 0; b_tag_cnt = 0;
      clear_mon();
      repeat (2) @(negedge clk);
      check("reset_outputs_a", {busy, done, tag_req, tag_set, line_req, line_set,
                                line_way, line_wb, line_inv}, 0);
      check("reset_outputs_b", {b_busy, b_done, b_tag_req, b_line_req}, 0);
      rst = 1'b0;

      // All lines clean: only tag reads, 256 sets x 3 cycles, then DONE.
      run_walk(1'b1, 1'b0, lat);
      check("clean_latency", lat, 769);
      check("clean_line_ops", n_ops, 0);
      check("clean_tag_reads", n_reads, 256);
      check("clean_tag_seq_err", seq_err, 0);
      check("clean_req_overlap", overlap, 0);

      // Set 5 dirty in ways 0,2,7; set 7 valid but clean (no writeback on fence).
      tv[5] = 8'b1000_0101; td[5] = 8'b1000_0101;
      tv[7] = 8'hFF;        td[7] = 8'h00;
      run_walk(1'b1, 1'b0, lat);
      check("dirty_latency", lat, 772);
      check("dirty_line_ops", n_ops, 3);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("dirty_op%0d_set", i), op_set[i], 5);
         check($sformatf("dirty_op%0d_wb", i), op_wb[i], 1);
         check($sformatf("dirty_op%0d_inv", i), op_inv[i], 0);
      end
      check("dirty_op0_way", op_way[0], 0);
      check("dirty_op1_way", op_way[1], 2);
      check("dirty_op2_way", op_way[2], 7);

      // Same walk with the first line op stalled 4 cycles.
      stall_left = 4;
      run_walk(1'b1, 1'b0, lat);
      check("stall_latency", lat, 776);
      check("stall_stable_err", stable_err, 0);
      check("stall_line_ops", n_ops, 3);
      check("stall_op0_way", op_way[0], 0);
      check("stall_op2_way", op_way[2], 7);

      // Explicit flush: valid lines invalidated, dirty ones also written back.
      tv[5] = '0; td[5] = '0; tv[7] = '0;
      tv[3] = 8'b0000_0011; td[3] = 8'b0000_0010;
      for (int k = 0; k < 2; k++) begin
         run_walk(k == 1, 1'b1, lat);
         check($sformatf("flush%0d_latency", k), lat, 771);
         check($sformatf("flush%0d_line_ops", k), n_ops, 2);
         check($sformatf("flush%0d_op0", k), {op_set[0], op_way[0], op_wb[0], op_inv[0]},
               {32'd3, 32'd0, 32'd0, 32'd1});
         check($sformatf("flush%0d_op1", k), {op_set[1], op_way[1], op_wb[1], op_inv[1]},
               {32'd3, 32'd1, 32'd1, 32'd1});
      end

      // Reset in the middle of scanning set 10.
      tv[3] = '0; td[3] = '0;
      tv[10] = 8'h11; td[10] = 8'h11;
      @(negedge clk);
      clear_mon();
      fence = 1'b1;
      found = 0;
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         if (line_req && line_set == 8'd10) begin
            found = 1;
            break;
         end
      end
      check("reset_scan_reached", found, 1);
      rst = 1'b1;
      #1;
      check("midwalk_reset_outputs", {busy, done, tag_req, tag_set, line_req, line_set,
                                      line_way, line_wb, line_inv}, 0);
      fence = 1'b0;
      found = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (done) found++;
      end
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (done) found++;
      end
      check("midwalk_reset_no_done", found, 0);
      run_walk(1'b1, 1'b0, lat);
      check("restart_latency", lat, 771);
      check("restart_tag_seq_err", seq_err, 0);
      check("restart_tag_reads", n_reads, 256);
      check("restart_line_ops", n_ops, 2);
      check("restart_op1_way", op_way[1], 4);

      // Fence with flush-on-fence disabled: immediate one-cycle done.
      @(negedge clk);
      b_fence = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("nofl_done_t1", b_done, 1);
      check("nofl_busy_t1", b_busy, 1);
      b_fence = 1'b0;
      @(negedge clk);
      check("nofl_done_t2", b_done, 0);
      check("nofl_busy_t2", b_busy, 0);
      check("nofl_array_traffic", b_tag_cnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
